// File: rtl/track_select_pkg.sv
// Shared constants and types for the track-index selector.
package track_select_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_CLAMP   = 2'd1;
    localparam logic [1:0] MODE_SHUFFLE = 2'd2;

    typedef enum logic [1:0] {IDLE, LOCK, WAIT_REL} state_t;

    // x^8 + x^6 + x^5 + x^4 + 1, taps on bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/track_select_if.sv
// Command/status bundle between the command decoders, the selector and playback.
interface track_select_if #(
    parameter int TRACK_W = 4,
    parameter int STEP_W  = 3
);
    logic [1:0]         MODE;
    logic [STEP_W-1:0]  PREV;
    logic [STEP_W-1:0]  NEXT;
    logic               LOAD;
    logic [TRACK_W-1:0] LOAD_IDX;
    logic               SONG_END;
    logic [TRACK_W-1:0] SW;
    logic               CHANGE;
    logic               BUSY;
    logic               LOAD_ERR;

    modport master (
        output MODE, PREV, NEXT, LOAD, LOAD_IDX, SONG_END,
        input  SW, CHANGE, BUSY, LOAD_ERR
    );

    modport slave (
        input  MODE, PREV, NEXT, LOAD, LOAD_IDX, SONG_END,
        output SW, CHANGE, BUSY, LOAD_ERR
    );
endinterface

// File: rtl/track_select_lfsr.sv
// 8-bit free-running Fibonacci LFSR used as the shuffle source.
module track_lfsr
    import track_select_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       ld,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)    q <= LFSR_SEED;
        else if (ld) q <= seed;
        else         q <= {q[6:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/track_select.sv
// Current-track selector: prev/next/load/song-end with lockout, release wait
// and wrap/clamp/shuffle navigation.
module track_select
    import track_select_pkg::*;
#(
    parameter int NUM_TRACKS = 10,
    parameter int TRACK_W    = 4,
    parameter int STEP_W     = 3,
    parameter int LOCKOUT    = 500000,
    parameter int CNT_W      = 20
) (
    input  logic          CLK,
    input  logic          RST,
    track_select_if.slave bus
);

    typedef logic [TRACK_W:0]   ext_t;
    typedef logic [TRACK_W-1:0] idx_t;

    localparam ext_t             N_EXT    = ext_t'(NUM_TRACKS);
    localparam idx_t             LAST     = idx_t'(NUM_TRACKS - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = (LOCKOUT == 0) ? '0 : CNT_W'(LOCKOUT - 1);
    localparam state_t           ACC_ST   = (LOCKOUT == 0) ? WAIT_REL : LOCK;

    if (NUM_TRACKS < 2 || (2**TRACK_W) < NUM_TRACKS) begin : g_bad_tracks
        $error("track_select: NUM_TRACKS must be >= 2 and fit in TRACK_W");
    end
    if ((2**STEP_W) - 1 >= NUM_TRACKS) begin : g_bad_step
        $error("track_select: largest step must be below NUM_TRACKS");
    end
    if (LOCKOUT >= (2**CNT_W)) begin : g_bad_cnt
        $error("track_select: CNT_W too narrow for LOCKOUT");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend_end;
    logic [7:0]       lfsr;
    idx_t             rnd;
    logic             load_ok;
    logic             acc;
    logic             srv_end;
    idx_t             acc_idx;

    track_lfsr u_lfsr (
        .CLK  (CLK),
        .RST  (RST),
        .ld   (1'b0),
        .seed (LFSR_SEED),
        .q    (lfsr)
    );

    assign rnd     = idx_t'(32'(lfsr) % NUM_TRACKS);
    assign load_ok = ext_t'(bus.LOAD_IDX) < N_EXT;
    assign bus.BUSY = (state != IDLE);

    // Forward step; shuffle ignores the step and never repeats the current track.
    function automatic idx_t fwd_idx(logic [1:0] m, logic [STEP_W-1:0] s, idx_t c, idx_t r);
        ext_t sum;
        sum = ext_t'(c) + ext_t'(s);
        if (m == MODE_SHUFFLE) return (r == c) ? ((c == LAST) ? '0 : c + idx_t'(1)) : r;
        if (m == MODE_CLAMP)   return (sum > ext_t'(LAST)) ? LAST : idx_t'(sum);
        return (sum >= N_EXT) ? idx_t'(sum - N_EXT) : idx_t'(sum);
    endfunction

    function automatic idx_t prev_idx(logic [1:0] m, logic [STEP_W-1:0] s, idx_t c);
        if (ext_t'(c) >= ext_t'(s)) return idx_t'(ext_t'(c) - ext_t'(s));
        if (m == MODE_CLAMP)        return '0;
        return idx_t'(ext_t'(c) + N_EXT - ext_t'(s));
    endfunction

    always_comb begin
        acc     = 1'b0;
        srv_end = 1'b0;
        acc_idx = bus.SW;
        if (bus.LOAD && load_ok) begin
            acc     = 1'b1;
            srv_end = 1'b1;
            acc_idx = bus.LOAD_IDX;
        end else if (state == IDLE) begin
            if (|bus.PREV) begin
                acc     = 1'b1;
                acc_idx = prev_idx(bus.MODE, bus.PREV, bus.SW);
            end else if (|bus.NEXT) begin
                acc     = 1'b1;
                acc_idx = fwd_idx(bus.MODE, bus.NEXT, bus.SW, rnd);
            end else if (pend_end || bus.SONG_END) begin
                acc     = 1'b1;
                srv_end = 1'b1;
                acc_idx = fwd_idx(bus.MODE, STEP_W'(1), bus.SW, rnd);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            cnt          <= '0;
            pend_end     <= 1'b0;
            bus.SW       <= '0;
            bus.CHANGE   <= 1'b0;
            bus.LOAD_ERR <= 1'b0;
        end else begin
            bus.CHANGE   <= acc && (acc_idx != bus.SW);
            bus.LOAD_ERR <= bus.LOAD && !load_ok;
            // A song end that loses arbitration stays pending until served.
            pend_end     <= srv_end ? 1'b0 : (pend_end | bus.SONG_END);
            if (acc) begin
                bus.SW <= acc_idx;
                cnt    <= CNT_INIT;
                state  <= ACC_ST;
            end else begin
                case (state)
                    LOCK: begin
                        if (cnt == '0) state <= WAIT_REL;
                        else           cnt   <= cnt - CNT_W'(1);
                    end
                    WAIT_REL: begin
                        if (!(|bus.PREV) && !(|bus.NEXT)) state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_track_select.sv
// Scenario bench for track_select: CHANGE pulses are scored against a queue of
// expected track indices, other behaviour is checked inline per scenario.
module tb_track_select;

    localparam int NT = 10;
    localparam int TW = 4;
    localparam int SWD = 3;
    localparam int LO = 4;

    logic CLK;
    logic RST;

    track_select_if #(.TRACK_W(TW), .STEP_W(SWD)) bus ();

    track_select #(
        .NUM_TRACKS (NT),
        .TRACK_W    (TW),
        .STEP_W     (SWD),
        .LOCKOUT    (LO),
        .CNT_W      (20)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_change = 0;
    logic mon_en = 1'b1;
    logic [TW-1:0] exp_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    // Advance one cycle and score any CHANGE pulse against the expected queue.
    task automatic cyc();
        logic [TW-1:0] e;
        @(negedge CLK);
        if (bus.CHANGE === 1'b1) begin
            n_change++;
            if (mon_en) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL change_unexpected: CHANGE with SW=%0d, no change expected", bus.SW);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.SW !== e) begin
                        n_fail++;
                        $display("FAIL change_value: SW=%0d, expected %0d", bus.SW, e);
                    end
                end
            end
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.BUSY === 1'b1 && k < 50) begin
            cyc();
            k++;
        end
        n_chk++;
        if (bus.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout: BUSY=%b after %0d cycles, expected 0", bus.BUSY, k);
        end
    endtask

    task automatic do_load(input logic [TW-1:0] idx);
        bus.LOAD = 1'b1;
        bus.LOAD_IDX = idx;
        cyc();
        bus.LOAD = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        bus.MODE = 2'd0; bus.PREV = '0; bus.NEXT = '0;
        bus.LOAD = 1'b0; bus.LOAD_IDX = '0; bus.SONG_END = 1'b0;
        repeat (2) @(negedge CLK);
        n_chk++;
        if ({bus.SW, bus.CHANGE, bus.BUSY, bus.LOAD_ERR} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: SW=%0d CHANGE=%b BUSY=%b LOAD_ERR=%b, expected all 0",
                     bus.SW, bus.CHANGE, bus.BUSY, bus.LOAD_ERR);
        end
        RST = 1'b1;
    endtask

    task automatic test_wrap_next();
        int c0, busy_n, k;
        exp_q.push_back(4'd8);
        do_load(4'd8);
        n_chk++;
        if (bus.SW !== 4'd8) begin n_fail++; $display("FAIL load_8: SW=%0d, expected 8", bus.SW); end
        wait_idle();
        bus.MODE = 2'd0;
        c0 = n_change;
        exp_q.push_back(4'd1);
        bus.NEXT = 3'd3;
        cyc();
        bus.NEXT = '0;
        n_chk++;
        if (bus.SW !== 4'd1 || bus.CHANGE !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_next: SW=%0d CHANGE=%b, expected SW=1 CHANGE=1", bus.SW, bus.CHANGE);
        end
        busy_n = 0; k = 0;
        while (bus.BUSY === 1'b1 && k < 20) begin busy_n++; cyc(); k++; end
        n_chk++;
        if (busy_n != LO + 1) begin n_fail++; $display("FAIL busy_len: BUSY high %0d cycles, expected %0d", busy_n, LO + 1); end
        n_chk++;
        if (n_change - c0 != 1) begin n_fail++; $display("FAIL wrap_change_cnt: %0d pulses, expected 1", n_change - c0); end
    endtask

    task automatic test_hold_prev();
        int c0, bad;
        c0 = n_change; bad = 0;
        exp_q.push_back(4'd9);
        bus.PREV = 3'd2;
        repeat (50) begin
            cyc();
            if (bus.SW !== 4'd9) bad++;
        end
        n_chk++;
        if (bad != 0) begin n_fail++; $display("FAIL hold_prev: SW off 9 on %0d cycles, expected 0", bad); end
        n_chk++;
        if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL hold_busy: BUSY=%b while held, expected 1", bus.BUSY); end
        bus.PREV = '0;
        cyc();
        n_chk++;
        if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL release_idle: BUSY=%b, expected 0", bus.BUSY); end
        n_chk++;
        if (n_change - c0 != 1) begin n_fail++; $display("FAIL hold_change_cnt: %0d pulses, expected 1", n_change - c0); end
    endtask

    task automatic test_clamp();
        int c0;
        bus.MODE = 2'd1;
        exp_q.push_back(4'd7);
        do_load(4'd7);
        wait_idle();
        exp_q.push_back(4'd9);
        bus.NEXT = 3'd5;
        cyc();
        bus.NEXT = '0;
        n_chk++;
        if (bus.SW !== 4'd9) begin n_fail++; $display("FAIL clamp_next: SW=%0d, expected 9", bus.SW); end
        wait_idle();
        c0 = n_change;
        bus.NEXT = 3'd1;
        cyc();
        bus.NEXT = '0;
        n_chk++;
        if (bus.SW !== 4'd9 || bus.CHANGE !== 1'b0 || bus.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_top: SW=%0d CHANGE=%b BUSY=%b, expected 9/0/1", bus.SW, bus.CHANGE, bus.BUSY);
        end
        wait_idle();
        bus.SONG_END = 1'b1;
        cyc();
        bus.SONG_END = 1'b0;
        n_chk++;
        if (bus.SW !== 4'd9 || bus.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_song_end: SW=%0d BUSY=%b, expected 9/1", bus.SW, bus.BUSY);
        end
        wait_idle();
        n_chk++;
        if (n_change != c0) begin n_fail++; $display("FAIL clamp_no_change: %0d pulses, expected 0", n_change - c0); end
        exp_q.push_back(4'd1);
        do_load(4'd1);
        wait_idle();
        exp_q.push_back(4'd0);
        bus.PREV = 3'd3;
        cyc();
        bus.PREV = '0;
        n_chk++;
        if (bus.SW !== 4'd0) begin n_fail++; $display("FAIL clamp_prev: SW=%0d, expected 0", bus.SW); end
        wait_idle();
    endtask

    task automatic test_song_end_load_err();
        int k;
        bus.MODE = 2'd0;
        exp_q.push_back(4'd4);
        do_load(4'd4);
        exp_q.push_back(4'd5);
        bus.SONG_END = 1'b1;
        k = 0;
        while (k < 20) begin
            cyc();
            k++;
            bus.SONG_END = 1'b0;
            if (bus.SW === 4'd5) break;
        end
        n_chk++;
        if (bus.SW !== 4'd5 || k != LO + 2) begin
            n_fail++;
            $display("FAIL pend_end: SW=%0d after %0d cycles, expected 5 after %0d", bus.SW, k, LO + 2);
        end
        do_load(4'd12);
        n_chk++;
        if (bus.SW !== 4'd5 || bus.LOAD_ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL load_err_12: SW=%0d LOAD_ERR=%b, expected 5/1", bus.SW, bus.LOAD_ERR);
        end
        cyc();
        n_chk++;
        if (bus.LOAD_ERR !== 1'b0) begin n_fail++; $display("FAIL load_err_pulse: LOAD_ERR=%b, expected 0", bus.LOAD_ERR); end
        do_load(4'd10);
        n_chk++;
        if (bus.SW !== 4'd5 || bus.LOAD_ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL load_err_10: SW=%0d LOAD_ERR=%b, expected 5/1", bus.SW, bus.LOAD_ERR);
        end
        wait_idle();
    endtask

    task automatic test_wrap_edges();
        bus.MODE = 2'd3;
        exp_q.push_back(4'd1);
        bus.NEXT = 3'd6;
        cyc();
        bus.NEXT = '0;
        n_chk++;
        if (bus.SW !== 4'd1) begin n_fail++; $display("FAIL mode3_next: SW=%0d, expected 1", bus.SW); end
        wait_idle();
        bus.MODE = 2'd0;
        exp_q.push_back(4'd4);
        bus.PREV = 3'd7;
        cyc();
        bus.PREV = '0;
        n_chk++;
        if (bus.SW !== 4'd4) begin n_fail++; $display("FAIL wrap_prev7: SW=%0d, expected 4", bus.SW); end
        wait_idle();
    endtask

    task automatic test_reset_mid_lock();
        exp_q.push_back(4'd6);
        do_load(4'd6);
        cyc();
        #2 RST = 1'b0;
        #1;
        n_chk++;
        if (bus.SW !== 4'd0 || bus.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: SW=%0d BUSY=%b, expected 0/0", bus.SW, bus.BUSY);
        end
        @(negedge CLK);
        RST = 1'b1;
        exp_q.push_back(4'd1);
        bus.NEXT = 3'd1;
        cyc();
        bus.NEXT = '0;
        n_chk++;
        if (bus.SW !== 4'd1) begin n_fail++; $display("FAIL post_reset_next: SW=%0d, expected 1", bus.SW); end
        wait_idle();
    endtask

    task automatic test_shuffle();
        logic [NT-1:0] hit;
        int prev, cur, bad_range, bad_rep, bad_chg;
        mon_en = 1'b0;
        bus.MODE = 2'd2;
        hit = '0; bad_range = 0; bad_rep = 0; bad_chg = 0;
        prev = 1;
        repeat (200) begin
            bus.SONG_END = 1'b1;
            cyc();
            bus.SONG_END = 1'b0;
            cur = int'(bus.SW);
            if (cur >= NT) bad_range++;
            else hit[cur] = 1'b1;
            if (cur == prev) bad_rep++;
            if (bus.CHANGE !== 1'b1) bad_chg++;
            prev = cur;
            wait_idle();
        end
        n_chk++;
        if (bad_range != 0) begin n_fail++; $display("FAIL shuffle_range: %0d out of range, expected 0", bad_range); end
        n_chk++;
        if (bad_rep != 0) begin n_fail++; $display("FAIL shuffle_repeat: %0d repeats, expected 0", bad_rep); end
        n_chk++;
        if (bad_chg != 0) begin n_fail++; $display("FAIL shuffle_change: %0d missing pulses, expected 0", bad_chg); end
        n_chk++;
        if (hit !== {NT{1'b1}}) begin n_fail++; $display("FAIL shuffle_cover: hit=%b, expected all ones", hit); end
        do_load(4'd3);
        wait_idle();
        mon_en = 1'b1;
        exp_q.push_back(4'd1);
        bus.PREV = 3'd2;
        cyc();
        bus.PREV = '0;
        n_chk++;
        if (bus.SW !== 4'd1) begin n_fail++; $display("FAIL shuffle_prev: SW=%0d, expected 1", bus.SW); end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_wrap_next();
        test_hold_prev();
        test_clamp();
        test_song_end_load_err();
        test_wrap_edges();
        test_reset_mid_lock();
        test_shuffle();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected changes never seen, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/track_select.md
Name: track_select

Overview:
Parametrised track-index selector for the MP3 player control path.
- Converts prev/next step requests, direct loads and end-of-song pulses into a current track index for the decoder/SD reader.
- Supports a post-change lockout, wait-for-release, and three navigation modes: wrap, clamp and shuffle.
- Sits between the button/Bluetooth command decoders and the playback controller.

Parameters:
NUM_TRACKS, 10, number of valid tracks; index range 0..NUM_TRACKS-1; must be >= 2
TRACK_W, 4, width of track index; 2**TRACK_W >= NUM_TRACKS
STEP_W, 3, width of PREV/NEXT step amount; 2**STEP_W-1 < NUM_TRACKS (elaboration-time check)
LOCKOUT, 500000, cycles of lockout after an accepted change; 0 = no lockout
CNT_W, 20, lockout counter width; 2**CNT_W > LOCKOUT

Ports:
CLK  in  1  system clock; all logic on posedge
RST  in  1  reset; asynchronous assert, active-low
MODE  in  2  0 = wrap, 1 = clamp, 2 = shuffle, 3 = treated as wrap
PREV  in  STEP_W  step-back amount; nonzero = request; synchronous to CLK
NEXT  in  STEP_W  step-forward amount; nonzero = request
LOAD  in  1  direct-select strobe
LOAD_IDX  in  TRACK_W  index for LOAD
SONG_END  in  1  one-cycle pulse from playback: auto-advance
SW  out  TRACK_W  current track index (registered)
CHANGE  out  1  one-cycle pulse on the cycle after SW changes
BUSY  out  1  high while not in IDLE
LOAD_ERR  out  1  one-cycle pulse when LOAD_IDX >= NUM_TRACKS

Behaviour:
Reset (RST low, async):
- SW=0, CHANGE=0, BUSY=0, LOAD_ERR=0.
- state=IDLE, lockout counter=0, pend_end=0, LFSR=8'hA5.

FSM states: IDLE, LOCK, WAIT_REL.
- IDLE:
  - Priority is LOAD > PREV > NEXT > pend_end/SONG_END.
  - An accepted event updates SW at that edge and loads counter=LOCKOUT-1.
  - Next state is LOCK, or WAIT_REL if LOCKOUT==0.
- LOCK:
  - Counter decrements each cycle.
  - At counter==0, go to WAIT_REL.
  - PREV/NEXT are ignored.
- WAIT_REL: go to IDLE on the first cycle PREV==0 and NEXT==0. Held buttons never auto-repeat.
- LOAD is accepted in any state:
  - Updates SW immediately.
  - Restarts the lockout (counter=LOCKOUT-1, state LOCK, or WAIT_REL if LOCKOUT==0).
- LOAD with LOAD_IDX >= NUM_TRACKS:
  - Ignored: SW unchanged, no state change.
  - LOAD_ERR pulses the next cycle.
- SONG_END outside IDLE sets pend_end. pend_end is served on the first IDLE cycle and cleared when served or by LOAD.

Arithmetic (step s, current c, N=NUM_TRACKS; internal width TRACK_W+1, no overflow):
- Wrap, NEXT: (c+s) >= N ? c+s-N : c+s.
- Wrap, PREV: c >= s ? c-s : c+N-s.
- Clamp: NEXT saturates at N-1; PREV saturates at 0.
- Shuffle, NEXT or SONG_END:
  - r = LFSR mod N.
  - If r==c, use (c+1) wrapped.
  - Step amount is ignored.
- Shuffle, PREV: behaves as wrap.
- SONG_END in wrap/clamp mode: step of 1. In clamp mode at N-1, SW stays put and CHANGE does not pulse.

CHANGE:
- Pulses the cycle after any edge where SW's value actually changes.
- An accepted event that leaves SW unchanged (clamp at end, LOAD of the current index) still enters LOCK but gives no CHANGE.

Other rules:
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; free-runs every cycle.
- MODE is sampled only at event acceptance. A mode change never alters SW by itself.
- Reset mid-LOCK: immediately IDLE with SW=0; the pending event is lost.

Decomposition:
- track_select_pkg holds:
  - mode constants (MODE_WRAP, MODE_CLAMP, MODE_SHUFFLE);
  - state enum (IDLE, LOCK, WAIT_REL);
  - LFSR seed 8'hA5 and tap mask.
- One sub-module, track_lfsr: 8-bit LFSR with CLK, async active-low RST and seed load. The modulo-N reduction stays in track_select.

Test Plan (NUM_TRACKS=10, LOCKOUT=4, STEP_W=3):
- Reset then wrap mode, NEXT=3 for 1 cycle at SW=8 -> SW=1, CHANGE pulses once, BUSY high for 4 LOCK cycles plus 1 WAIT_REL cycle, then IDLE.
- Wrap mode, PREV=2 at SW=1 -> SW=9. Hold PREV=2 for 50 cycles -> SW stays 9 until release, with exactly one CHANGE.
- Clamp mode, NEXT=5 at SW=7 -> SW=9. Then after IDLE, NEXT=1 -> SW=9, CHANGE=0, BUSY still asserts.
- SONG_END during LOCK at SW=4 (wrap) -> SW=5 on the first IDLE cycle. LOAD with LOAD_IDX=12 -> SW unchanged, LOAD_ERR pulses 1 cycle.
- Shuffle, 200 SONG_END pulses spaced beyond the lockout -> SW always in 0..9, never equal to the previous SW, and every index hit at least once.
- Assert RST mid-LOCK with SW=6 -> SW=0, BUSY=0 asynchronously. After release, NEXT=1 -> SW=1.
